// File: rtl/pfrv_pkg.sv
// Shared pipeline types and constants for the pfrv RV64 core.
// The optional FETCH_MISALIGN_EN macro adds a misalign flag to the IF/ID record.
package pfrv_pkg;

  localparam int XLEN    = 64;
  localparam int IMEM_AW = 6;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [31:0]     instr;
    logic            valid;
`ifdef FETCH_MISALIGN_EN
    logic            misalign;
`endif
  } ifid_t;

  // Bubble record: a NOP that is not a real instruction, tagged with a PC.
  function automatic ifid_t ifid_bubble(input logic [XLEN-1:0] pc);
    ifid_t b;
    b       = '0;
    b.pc    = pc;
    b.pc4   = pc + 64'd4;
    b.instr = NOP_INSTR;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register with load, hold and flush; async reset to the bubble.
// Flush has priority over load so a redirect always kills the captured word.
module ifid_reg
  import pfrv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  input  ifid_t           d_i,
  output ifid_t           q_o
);

  ifid_t q_q;
  ifid_t q_d;

  // Next-state selection: flush, load, or hold.
  always_comb begin
    q_d = q_q;
    if (flush_i) begin
      q_d = ifid_bubble(flush_pc_i);
    end else if (load_i) begin
      q_d = d_i;
    end else begin
      q_d = q_q;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= ifid_bubble({XLEN{1'b0}});
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// RV64 instruction-fetch stage: owns the PC, addresses the ROM, fills IF/ID.
// Define FETCH_MISALIGN_EN to add the ifid_misalign_o output.
module fetch_stage
  import pfrv_pkg::*;
#(
  parameter int           N        = 64,
  parameter int           IMEM_AW  = 6,
  parameter logic [N-1:0] RESET_PC = 64'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [N-1:0]       redirect_pc_i,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [31:0]        imem_q_i,
  output logic [N-1:0]       ifid_pc_o,
  output logic [N-1:0]       ifid_pc4_o,
  output logic [31:0]        ifid_instr_o,
`ifdef FETCH_MISALIGN_EN
  output logic               ifid_misalign_o,
`endif
  output logic               ifid_valid_o
);

  logic [N-1:0] pc_q;
  logic [N-1:0] pc_d;
  logic         first_q;
  logic         load_s;
  logic         flush_s;
  ifid_t        ifid_d;
  ifid_t        ifid_q;

  // PC next-state and IF/ID control; redirect beats stall beats advance.
  always_comb begin
    pc_d    = pc_q;
    load_s  = 1'b0;
    flush_s = 1'b0;
    if (redirect_i) begin
      pc_d    = redirect_pc_i;
      flush_s = 1'b1;
    end else if (stall_i) begin
      // A stall on the very first edge keeps IF/ID a bubble.
      flush_s = first_q;
    end else begin
      pc_d   = pc_q + 64'd4;
      load_s = 1'b1;
    end
  end

  // Record captured into IF/ID on a normal advance.
  always_comb begin
    ifid_d       = '0;
    ifid_d.pc    = XLEN'(pc_q);
    ifid_d.pc4   = XLEN'(pc_q + 64'd4);
    ifid_d.instr = imem_q_i;
    ifid_d.valid = 1'b1;
`ifdef FETCH_MISALIGN_EN
    ifid_d.misalign = |pc_q[1:0];
`endif
  end

  // Program counter and first-edge flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      first_q <= 1'b1;
    end else begin
      pc_q    <= pc_d;
      first_q <= 1'b0;
    end
  end

  ifid_reg u_ifid_reg (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_s),
    .flush_i    (flush_s),
    .flush_pc_i (XLEN'(pc_q)),
    .d_i        (ifid_d),
    .q_o        (ifid_q)
  );

  assign imem_addr_o  = pc_q[IMEM_AW+1:2];
  assign ifid_pc_o    = N'(ifid_q.pc);
  assign ifid_pc4_o   = N'(ifid_q.pc4);
  assign ifid_instr_o = ifid_q.instr;
  assign ifid_valid_o = ifid_q.valid;
`ifdef FETCH_MISALIGN_EN
  assign ifid_misalign_o = ifid_q.misalign;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a behavioural ROM.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic [5:0]  imem_addr_o;
  logic [31:0] imem_q_i;
  logic [63:0] ifid_pc_o;
  logic [63:0] ifid_pc4_o;
  logic [31:0] ifid_instr_o;
  logic        ifid_valid_o;
`ifdef FETCH_MISALIGN_EN
  logic        ifid_misalign_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [5:0] a);
    case (a)
      6'd0:    return 32'h0000_3023;
      6'd1:    return 32'h0000_0f93;
      6'd2:    return 32'h4000_0113;
      6'd3:    return 32'h0600_006f;
      default: return 32'hC000_0000 | {26'd0, a};
    endcase
  endfunction

  assign imem_q_i = rom_word(imem_addr_o);

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_q_i      (imem_q_i),
    .ifid_pc_o     (ifid_pc_o),
    .ifid_pc4_o    (ifid_pc4_o),
    .ifid_instr_o  (ifid_instr_o),
`ifdef FETCH_MISALIGN_EN
    .ifid_misalign_o (ifid_misalign_o),
`endif
    .ifid_valid_o  (ifid_valid_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [5:0] addr, input logic [63:0] pc,
                           input logic [31:0] instr, input logic valid);
    check({tag, " addr"},  {58'd0, imem_addr_o}, {58'd0, addr});
    check({tag, " pc"},    ifid_pc_o, pc);
    check({tag, " pc4"},   ifid_pc4_o, pc + 64'd4);
    check({tag, " instr"}, {32'd0, ifid_instr_o}, {32'd0, instr});
    check({tag, " valid"}, {63'd0, ifid_valid_o}, {63'd0, valid});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [63:0] rpc;
    logic [5:0]  addr;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic [63:0] rpc,
                              input logic [5:0] addr, input logic [63:0] pc,
                              input logic [31:0] instr, input logic valid);
    vec_t v;
    v.stall = s; v.redir = r; v.rpc = rpc; v.addr = addr;
    v.pc = pc; v.instr = instr; v.valid = valid;
    return v;
  endfunction

  localparam logic [31:0] NOP = 32'h0000_0013;
  vec_t vt[26];

  initial begin
    // Free-run from reset, redirect to 0x6C at pc 0x10.
    vt[0]  = mk(1'b0, 1'b0, 64'h0,   6'd1,    64'h0,   32'h0000_3023, 1'b1);
    vt[1]  = mk(1'b0, 1'b0, 64'h0,   6'd2,    64'h4,   32'h0000_0f93, 1'b1);
    vt[2]  = mk(1'b0, 1'b0, 64'h0,   6'd3,    64'h8,   32'h4000_0113, 1'b1);
    vt[3]  = mk(1'b0, 1'b0, 64'h0,   6'd4,    64'hC,   32'h0600_006f, 1'b1);
    vt[4]  = mk(1'b0, 1'b1, 64'h6C,  6'h1B,   64'h10,  NOP,            1'b0);
    vt[5]  = mk(1'b0, 1'b0, 64'h0,   6'h1C,   64'h6C,  32'hC000_001B, 1'b1);
    vt[6]  = mk(1'b0, 1'b0, 64'h0,   6'h1D,   64'h70,  32'hC000_001C, 1'b1);
    vt[7]  = mk(1'b0, 1'b0, 64'h0,   6'h1E,   64'h74,  32'hC000_001D, 1'b1);
    vt[8]  = mk(1'b0, 1'b0, 64'h0,   6'h1F,   64'h78,  32'hC000_001E, 1'b1);
    vt[9]  = mk(1'b0, 1'b0, 64'h0,   6'h20,   64'h7C,  32'hC000_001F, 1'b1);
    vt[10] = mk(1'b0, 1'b0, 64'h0,   6'h21,   64'h80,  32'hC000_0020, 1'b1);
    // Three-cycle stall at pc 0x84, then resume.
    vt[11] = mk(1'b1, 1'b0, 64'h0,   6'h21,   64'h80,  32'hC000_0020, 1'b1);
    vt[12] = mk(1'b1, 1'b0, 64'h0,   6'h21,   64'h80,  32'hC000_0020, 1'b1);
    vt[13] = mk(1'b1, 1'b0, 64'h0,   6'h21,   64'h80,  32'hC000_0020, 1'b1);
    vt[14] = mk(1'b0, 1'b0, 64'h0,   6'h22,   64'h84,  32'hC000_0021, 1'b1);
    // Stall and redirect together: redirect wins.
    vt[15] = mk(1'b1, 1'b1, 64'h90,  6'h24,   64'h88,  NOP,            1'b0);
    vt[16] = mk(1'b0, 1'b0, 64'h0,   6'h25,   64'h90,  32'hC000_0024, 1'b1);
    // Walk across the 0xFC -> 0x100 ROM wrap.
    vt[17] = mk(1'b0, 1'b1, 64'hF0,  6'h3C,   64'h94,  NOP,            1'b0);
    vt[18] = mk(1'b0, 1'b0, 64'h0,   6'h3D,   64'hF0,  32'hC000_003C, 1'b1);
    vt[19] = mk(1'b0, 1'b0, 64'h0,   6'h3E,   64'hF4,  32'hC000_003D, 1'b1);
    vt[20] = mk(1'b0, 1'b0, 64'h0,   6'h3F,   64'hF8,  32'hC000_003E, 1'b1);
    vt[21] = mk(1'b0, 1'b0, 64'h0,   6'h00,   64'hFC,  32'hC000_003F, 1'b1);
    vt[22] = mk(1'b0, 1'b0, 64'h0,   6'h01,   64'h100, 32'h0000_3023, 1'b1);
    // Self-loop redirects re-fetch the same word.
    vt[23] = mk(1'b0, 1'b1, 64'h104, 6'h01,   64'h104, NOP,            1'b0);
    vt[24] = mk(1'b0, 1'b1, 64'h104, 6'h01,   64'h104, NOP,            1'b0);
    vt[25] = mk(1'b0, 1'b0, 64'h0,   6'h02,   64'h104, 32'h0000_0f93, 1'b1);

    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 64'h0;
    #12;
    check_all("reset", 6'd0, 64'h0, NOP, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 26; i++) begin
      stall_i       = vt[i].stall;
      redirect_i    = vt[i].redir;
      redirect_pc_i = vt[i].rpc;
      step();
      check_all($sformatf("vec%0d", i), vt[i].addr, vt[i].pc, vt[i].instr, vt[i].valid);
    end
    stall_i = 1'b0; redirect_i = 1'b0;

    // Asynchronous reset mid-cycle while IF/ID holds a valid word.
    #3;
    reset = 1'b1;
    #1;
    check_all("async_rst", 6'd0, 64'h0, NOP, 1'b0);

    // Release reset during a stall: first edge keeps the bubble and pc.
    stall_i = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step();
    check_all("rst_stall", 6'd0, 64'h0, NOP, 1'b0);
    stall_i = 1'b0;
    step();
    check_all("rst_resume", 6'd1, 64'h0, 32'h0000_3023, 1'b1);

`ifdef FETCH_MISALIGN_EN
    redirect_i = 1'b1; redirect_pc_i = 64'h6E;
    step();
    redirect_i = 1'b0;
    check("mis_flush", {63'd0, ifid_misalign_o}, 64'd0);
    check("mis_addr", {58'd0, imem_addr_o}, 64'h1B);
    step();
    check("mis_set", {63'd0, ifid_misalign_o}, 64'd1);
    check("mis_pc", ifid_pc_o, 64'h6E);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
